// File: rtl/fht_in_buffer_pkg.sv
// ============================================================================
// Module      : fht_pkg
// Description : Shared widths and sample types for the FHT input path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fht_pkg;

    localparam int FHT_DW   = 13;
    localparam int FHT_N    = 16;
    localparam int FHT_IDXW = 4;

    typedef logic [FHT_DW-1:0] fht_sample_t;
    // One extra bit of headroom for the first butterfly add/subtract.
    typedef logic [FHT_DW:0]   fht_bfly_t;

endpackage

`default_nettype wire

// File: rtl/fht_in_buffer_if.sv
// ============================================================================
// Module      : fht_in_buffer_if
// Description : Chip-sample input and parallel-frame output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fht_in_buffer_if;
    import fht_pkg::*;

    logic        SymStart;
    logic        DinValid;
    fht_sample_t Din;
    fht_sample_t Out [FHT_N];   // Out[k] is frame word k
    logic        FhtStar;
    logic        FrameDrop;
    logic        Busy;

    // master: sample source / butterfly consumer side
    modport master (
        output SymStart, DinValid, Din,
        input  Out, FhtStar, FrameDrop, Busy
    );

    // slave: the input buffer itself
    modport slave (
        input  SymStart, DinValid, Din,
        output Out, FhtStar, FrameDrop, Busy
    );

endinterface

`default_nettype wire

// File: rtl/fht_in_buffer_wr_ctrl.sv
// ============================================================================
// Module      : fht_wr_ctrl
// Description : Write index, restart handling and frame-complete decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fht_wr_ctrl
    import fht_pkg::*;
(
    input  wire logic             Clk,
    input  wire logic             Reset,
    input  wire logic             i_sym_start,
    input  wire logic             i_din_valid,
    output logic [FHT_N-1:0]      o_wr_en,
    output logic                  o_load,
    output logic                  o_fht_star,
    output logic                  o_frame_drop,
    output logic                  o_busy
);

    localparam logic [FHT_IDXW-1:0] c_LAST_IDX = FHT_IDXW'(FHT_N - 1);
    localparam logic [FHT_IDXW-1:0] c_ONE      = FHT_IDXW'(1);

    logic [FHT_IDXW-1:0] r_wr_idx;
    logic [FHT_IDXW-1:0] w_wr_idx_nxt;
    logic                w_drop_nxt;
    logic                r_fht_star;
    logic                r_frame_drop;
    logic                r_busy;

    always_comb begin
        w_wr_idx_nxt = r_wr_idx;
        w_drop_nxt   = 1'b0;
        o_wr_en      = '0;
        o_load       = 1'b0;
        // SymStart always restarts, even without a sample; a restart at
        // index 15 therefore takes priority over frame completion.
        if (i_sym_start) begin
            w_drop_nxt = (r_wr_idx != '0);
            if (i_din_valid) begin
                o_wr_en[0]   = 1'b1;
                w_wr_idx_nxt = c_ONE;
            end else begin
                w_wr_idx_nxt = '0;
            end
        end else if (i_din_valid) begin
            o_wr_en[r_wr_idx] = 1'b1;
            o_load            = (r_wr_idx == c_LAST_IDX);
            w_wr_idx_nxt      = r_wr_idx + c_ONE;   // 15 wraps to 0
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wr_idx     <= '0;
            r_fht_star   <= 1'b0;
            r_frame_drop <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_wr_idx     <= w_wr_idx_nxt;
            r_fht_star   <= o_load;
            r_frame_drop <= w_drop_nxt;
            r_busy       <= (w_wr_idx_nxt != '0);
        end
    end

    assign o_fht_star   = r_fht_star;
    assign o_frame_drop = r_frame_drop;
    assign o_busy       = r_busy;

endmodule

`default_nettype wire

// File: rtl/fht_in_buffer.sv
// ============================================================================
// Module      : fht_in_buffer
// Description : Double-buffered 16-sample serial-to-parallel FHT input buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fht_in_buffer
    import fht_pkg::*;
#(
    parameter int DW = FHT_DW,
    parameter int N  = FHT_N       // only 16 is supported
)
(
    input  wire logic       Clk,
    input  wire logic       Reset,
    fht_in_buffer_if.slave  bus
);

    logic [N-1:0] w_wr_en;
    logic         w_load;

    fht_wr_ctrl u_wr_ctrl (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_sym_start  (bus.SymStart),
        .i_din_valid  (bus.DinValid),
        .o_wr_en      (w_wr_en),
        .o_load       (w_load),
        .o_fht_star   (bus.FhtStar),
        .o_frame_drop (bus.FrameDrop),
        .o_busy       (bus.Busy)
    );

    for (genvar k = 0; k < N; k++) begin : g_bank
        logic [DW-1:0] r_work;
        logic [DW-1:0] r_out;
        logic [DW-1:0] w_load_val;

        // The last word arrives on the load edge itself, so it bypasses
        // the working bank to allow back-to-back frames.
        if (k == N - 1) begin : g_last
            assign w_load_val = bus.Din;
        end else begin : g_mid
            assign w_load_val = r_work;
        end

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                r_work <= '0;
                r_out  <= '0;
            end else begin
                if (w_wr_en[k]) begin
                    r_work <= bus.Din;
                end
                if (w_load) begin
                    r_out <= w_load_val;
                end
            end
        end

        assign bus.Out[k] = r_out;
    end

endmodule

`default_nettype wire

// File: tb/tb_fht_in_buffer.sv
// ============================================================================
// Module      : tb_fht_in_buffer
// Description : Directed bench with a queue-based frame model for fht_in_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fht_in_buffer;

    logic Clk;
    logic Reset;
    fht_in_buffer_if bus ();

    fht_in_buffer #(.DW(13), .N(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Frame model: accepted samples queue up until 16 are collected.
    logic [12:0] m_frame [$];
    logic [12:0] m_out [16];
    logic        m_star, m_drop, m_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame.delete();
        for (int k = 0; k < 16; k++) m_out[k] = '0;
        m_star = 1'b0;
        m_drop = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [12:0] d);
        m_star = 1'b0;
        m_drop = 1'b0;
        if (s) begin
            m_drop = (m_frame.size() != 0);
            m_frame.delete();
        end
        if (v) begin
            m_frame.push_back(d);
            if (m_frame.size() == 16) begin
                for (int k = 0; k < 16; k++) m_out[k] = m_frame[k];
                m_star = 1'b1;
                m_frame.delete();
            end
        end
        m_busy = (m_frame.size() != 0);
    endtask

    task automatic cyc(input logic s, input logic v, input logic [12:0] d);
        @(negedge Clk);
        bus.SymStart = s;
        bus.DinValid = v;
        bus.Din      = d;
        @(posedge Clk);
        if (Reset) model_step(s, v, d);
        #1;
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int k = 0; k < 16; k++)
                chk($sformatf("Out%0d", k), 32'(bus.Out[k]), 32'(m_out[k]));
            chk("FhtStar",   32'(bus.FhtStar),   32'(m_star));
            chk("FrameDrop", 32'(bus.FrameDrop), 32'(m_drop));
            chk("Busy",      32'(bus.Busy),      32'(m_busy));
        end
    end

    logic [12:0] neg_vals [16];

    initial begin
        bus.SymStart = 1'b0;
        bus.DinValid = 1'b0;
        bus.Din      = '0;
        Reset = 1'b1;
        model_reset();
        #1 Reset = 1'b0;
        chk_en = 1'b1;
        #3;
        chk("rst_Out0", 32'(bus.Out[0]), 32'h0);
        chk("rst_FhtStar", 32'(bus.FhtStar), 32'h0);
        chk("rst_Busy", 32'(bus.Busy), 32'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        // 1: single frame 1..16
        cyc(1'b1, 1'b1, 13'd1);
        for (int i = 2; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 13'(i));
            chk("t1_star", 32'(bus.FhtStar), (i == 16) ? 32'd1 : 32'd0);
        end
        chk("t1_Out0", 32'(bus.Out[0]), 32'd1);
        chk("t1_Out15", 32'(bus.Out[15]), 32'd16);
        cyc(1'b0, 1'b0, '0);
        chk("t1_star_off", 32'(bus.FhtStar), 32'd0);

        // 2: three back-to-back frames
        for (int n = 0; n < 48; n++) begin
            cyc(n == 0, 1'b1, 13'(32'h1000 + n));
            chk("t2_star", 32'(bus.FhtStar), ((n + 1) % 16 == 0) ? 32'd1 : 32'd0);
        end
        chk("t2_Out0", 32'(bus.Out[0]), 32'h1020);
        chk("t2_Out15", 32'(bus.Out[15]), 32'h102F);

        // 3: five-cycle gap after sample 7
        cyc(1'b1, 1'b1, 13'h100);
        for (int i = 1; i < 7; i++) cyc(1'b0, 1'b1, 13'(32'h100 + i));
        for (int g = 0; g < 5; g++) begin
            cyc(1'b0, 1'b0, 13'h1ABC);
            chk("t3_gap_Out0", 32'(bus.Out[0]), 32'h1020);
            chk("t3_gap_star", 32'(bus.FhtStar), 32'd0);
        end
        for (int i = 7; i < 16; i++) cyc(1'b0, 1'b1, 13'(32'h100 + i));
        chk("t3_star", 32'(bus.FhtStar), 32'd1);
        chk("t3_Out6", 32'(bus.Out[6]), 32'h106);
        chk("t3_Out7", 32'(bus.Out[7]), 32'h107);
        chk("t3_Out15", 32'(bus.Out[15]), 32'h10F);

        // 4: SymStart at sample 9
        cyc(1'b1, 1'b1, 13'h200);
        for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, 13'(32'h200 + i));
        cyc(1'b1, 1'b1, 13'h0AAA);
        chk("t4_drop", 32'(bus.FrameDrop), 32'd1);
        chk("t4_nostar", 32'(bus.FhtStar), 32'd0);
        for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, 13'(32'h0AB0 + i));
        chk("t4_star", 32'(bus.FhtStar), 32'd1);
        chk("t4_Out0", 32'(bus.Out[0]), 32'h0AAA);
        chk("t4_Out1", 32'(bus.Out[1]), 32'h0AB1);

        // 5: negative and boundary samples pass bit-exact
        neg_vals = '{13'h1FFF, 13'h1000, 13'h0FFF, 13'h0001, 13'h1001, 13'h1800,
                     13'h07FF, 13'h0000, 13'h1555, 13'h0AAA, 13'h1FFE, 13'h1234,
                     13'h0F0F, 13'h10F0, 13'h1F00, 13'h0080};
        for (int i = 0; i < 16; i++) cyc(i == 0, 1'b1, neg_vals[i]);
        for (int k = 0; k < 16; k++)
            chk($sformatf("t5_Out%0d", k), 32'(bus.Out[k]), 32'(neg_vals[k]));

        // 7: SymStart exactly at index 15, then SymStart without a sample
        cyc(1'b1, 1'b1, 13'h400);
        for (int i = 1; i < 15; i++) cyc(1'b0, 1'b1, 13'(32'h400 + i));
        cyc(1'b1, 1'b1, 13'h0555);
        chk("t7_drop", 32'(bus.FrameDrop), 32'd1);
        chk("t7_nostar", 32'(bus.FhtStar), 32'd0);
        chk("t7_hold_Out0", 32'(bus.Out[0]), 32'h1FFF);
        for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, 13'(32'h0560 + i));
        chk("t7_Out0", 32'(bus.Out[0]), 32'h0555);
        cyc(1'b0, 1'b1, 13'h0777);
        cyc(1'b1, 1'b0, '0);
        chk("t7_drop_novalid", 32'(bus.FrameDrop), 32'd1);
        chk("t7_busy_clr", 32'(bus.Busy), 32'd0);

        // 6: reset after 12 samples, then a fresh frame
        cyc(1'b1, 1'b1, 13'h0900);
        for (int i = 1; i < 12; i++) cyc(1'b0, 1'b1, 13'(32'h0900 + i));
        bus.DinValid = 1'b0;
        bus.SymStart = 1'b0;
        #2 Reset = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_Out0", 32'(bus.Out[0]), 32'h0);
        chk("t6_rst_Out15", 32'(bus.Out[15]), 32'h0);
        chk("t6_rst_Busy", 32'(bus.Busy), 32'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, '0);
            chk("t6_no_star", 32'(bus.FhtStar), 32'd0);
            chk("t6_no_drop", 32'(bus.FrameDrop), 32'd0);
        end
        for (int i = 0; i < 16; i++) cyc(i == 0, 1'b1, 13'(32'h0300 + i));
        chk("t6_star", 32'(bus.FhtStar), 32'd1);
        chk("t6_Out0", 32'(bus.Out[0]), 32'h300);
        chk("t6_Out15", 32'(bus.Out[15]), 32'h30F);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
